// File: rtl/regfile_param.sv
// Parameterised register file: byte-enabled write port with read bypass, two
// combinational read ports, and a per-register pending (scoreboard) bit with count.
module regfile_param #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 16,
  parameter int ZERO_REG0 = 1,
  localparam int AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int NB       = WIDTH / 8
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [NB-1:0]    wbe,
  input  logic             rsv,
  input  logic [AW-1:0]    rsv_addr,
  input  logic [AW-1:0]    raddr_a,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] rdata_a,
  output logic [WIDTH-1:0] rdata_b,
  output logic             pend_a,
  output logic             pend_b,
  output logic [AW:0]      pend_cnt
);

  localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [DEPTH-1:0] pend_r;
  logic [DEPTH-1:0] pend_nxt_s;
  logic [AW:0]      pend_cnt_nxt_s;

  // Storage exists only below DEPTH; register 0 is read-only zero when hardwired.
  function automatic logic writable(input logic [AW-1:0] a);
    logic ok;
    ok = ({1'b0, a} < DEPTH_V);
    if ((ZERO_REG0 != 0) && (a == '0)) begin
      ok = 1'b0;
    end else begin
      ok = ok;
    end
    return ok;
  endfunction

  function automatic logic [WIDTH-1:0] byte_merge(input logic [WIDTH-1:0] old,
                                                  input logic [WIDTH-1:0] data,
                                                  input logic [NB-1:0]    be);
    logic [WIDTH-1:0] res;
    res = old;
    for (int b = 0; b < NB; b++) begin
      if (be[b]) begin
        res[8*b +: 8] = data[8*b +: 8];
      end else begin
        res[8*b +: 8] = old[8*b +: 8];
      end
    end
    return res;
  endfunction

  // Read ports: unmapped/hardwired addresses read 0; a same-cycle write is forwarded.
  always_comb begin
    rdata_a = '0;
    rdata_b = '0;
    pend_a  = 1'b0;
    pend_b  = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((raddr_a == AW'(i)) && writable(AW'(i))) begin
        pend_a = pend_r[i];
        if (we && (waddr == AW'(i))) begin
          rdata_a = byte_merge(mem_r[i], wdata, wbe);
        end else begin
          rdata_a = mem_r[i];
        end
      end else begin
        rdata_a = rdata_a;
      end
      if ((raddr_b == AW'(i)) && writable(AW'(i))) begin
        pend_b = pend_r[i];
        if (we && (waddr == AW'(i))) begin
          rdata_b = byte_merge(mem_r[i], wdata, wbe);
        end else begin
          rdata_b = mem_r[i];
        end
      end else begin
        rdata_b = rdata_b;
      end
    end
  end

  // Next pending vector (a reserve beats a write to the same register) and its population count.
  always_comb begin
    pend_nxt_s     = pend_r;
    pend_cnt_nxt_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rsv && (rsv_addr == AW'(i)) && writable(AW'(i))) begin
        pend_nxt_s[i] = 1'b1;
      end else if (we && (waddr == AW'(i)) && writable(AW'(i))) begin
        pend_nxt_s[i] = 1'b0;
      end else begin
        pend_nxt_s[i] = pend_r[i];
      end
      pend_cnt_nxt_s = pend_cnt_nxt_s + {{AW{1'b0}}, pend_nxt_s[i]};
    end
  end

  // State update: byte-enabled write, pending bits and registered pending count.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      pend_r   <= '0;
      pend_cnt <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (we && (waddr == AW'(i)) && writable(AW'(i))) begin
          mem_r[i] <= byte_merge(mem_r[i], wdata, wbe);
        end
      end
      pend_r   <= pend_nxt_s;
      pend_cnt <= pend_cnt_nxt_s;
    end
  end

endmodule

// File: tb/tb_regfile_param.sv
// Directed self-checking bench for regfile_param: default 32x16 instance with
// hardwired r0, plus a 16-bit x 4 instance where r0 is an ordinary register.
module tb_regfile_param;

  logic clock = 1'b0;
  logic clear = 1'b0;
  always #5 clock = ~clock;

  logic        we, rsv;
  logic [3:0]  waddr, rsv_addr, raddr_a, raddr_b, wbe;
  logic [31:0] wdata, rdata_a, rdata_b;
  logic        pend_a, pend_b;
  logic [4:0]  pend_cnt;

  logic        s_we, s_rsv;
  logic [1:0]  s_waddr, s_rsv_addr, s_raddr_a, s_raddr_b, s_wbe;
  logic [15:0] s_wdata, s_rdata_a, s_rdata_b;
  logic        s_pend_a, s_pend_b;
  logic [2:0]  s_pend_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  regfile_param u_dut (
    .clock(clock), .clear(clear), .we(we), .waddr(waddr), .wdata(wdata), .wbe(wbe),
    .rsv(rsv), .rsv_addr(rsv_addr), .raddr_a(raddr_a), .raddr_b(raddr_b),
    .rdata_a(rdata_a), .rdata_b(rdata_b), .pend_a(pend_a), .pend_b(pend_b),
    .pend_cnt(pend_cnt)
  );

  regfile_param #(.WIDTH(16), .DEPTH(4), .ZERO_REG0(0)) u_small (
    .clock(clock), .clear(clear), .we(s_we), .waddr(s_waddr), .wdata(s_wdata), .wbe(s_wbe),
    .rsv(s_rsv), .rsv_addr(s_rsv_addr), .raddr_a(s_raddr_a), .raddr_b(s_raddr_b),
    .rdata_a(s_rdata_a), .rdata_b(s_rdata_b), .pend_a(s_pend_a), .pend_b(s_pend_b),
    .pend_cnt(s_pend_cnt)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    we = 1'b0; rsv = 1'b0; waddr = 4'd0; rsv_addr = 4'd0; wdata = 32'd0; wbe = 4'd0;
  endtask

  task automatic test_reset();
    idle();
    raddr_a = 4'd5; raddr_b = 4'd7;
    s_we = 1'b0; s_rsv = 1'b0; s_waddr = 2'd0; s_rsv_addr = 2'd0; s_wdata = 16'd0;
    s_wbe = 2'd0; s_raddr_a = 2'd0; s_raddr_b = 2'd3;
    #2 clear = 1'b1;
    tick();
    clear = 1'b0;
    #1;
    n_cmp++; if (rdata_a !== 32'd0) begin n_bad++; $display("FAIL reset_rdata got=%h exp=0", rdata_a); end
    n_cmp++; if (pend_cnt !== 5'd0) begin n_bad++; $display("FAIL reset_pend_cnt got=%0d exp=0", pend_cnt); end
    n_cmp++; if (pend_b !== 1'b0) begin n_bad++; $display("FAIL reset_pend_b got=%b exp=0", pend_b); end
  endtask

  task automatic test_write_read();
    we = 1'b1; waddr = 4'd5; wdata = 32'hDEADBEEF; wbe = 4'b1111;
    tick();
    idle();
    raddr_a = 4'd5;
    #1;
    n_cmp++; if (rdata_a !== 32'hDEADBEEF) begin n_bad++; $display("FAIL write_read got=%h exp=deadbeef", rdata_a); end
  endtask

  task automatic test_bypass();
    we = 1'b1; waddr = 4'd5; wdata = 32'h11223344; wbe = 4'b0101;
    raddr_a = 4'd6; raddr_b = 4'd5;
    #1;
    n_cmp++; if (rdata_b !== 32'hDE22BE44) begin n_bad++; $display("FAIL bypass_b got=%h exp=de22be44", rdata_b); end
    n_cmp++; if (rdata_a !== 32'd0) begin n_bad++; $display("FAIL bypass_other_port got=%h exp=0", rdata_a); end
    tick();
    idle();
    raddr_a = 4'd5;
    #1;
    n_cmp++; if (rdata_a !== 32'hDE22BE44) begin n_bad++; $display("FAIL bypass_stored got=%h exp=de22be44", rdata_a); end
  endtask

  task automatic test_zero_reg();
    we = 1'b1; waddr = 4'd0; wdata = 32'hFFFFFFFF; wbe = 4'b1111; raddr_a = 4'd0;
    #1;
    n_cmp++; if (rdata_a !== 32'd0) begin n_bad++; $display("FAIL r0_same_cycle got=%h exp=0", rdata_a); end
    tick();
    idle();
    #1;
    n_cmp++; if (rdata_a !== 32'd0) begin n_bad++; $display("FAIL r0_next_cycle got=%h exp=0", rdata_a); end
    rsv = 1'b1; rsv_addr = 4'd0;
    tick();
    idle();
    n_cmp++; if (pend_cnt !== 5'd0) begin n_bad++; $display("FAIL r0_rsv_cnt got=%0d exp=0", pend_cnt); end
    n_cmp++; if (pend_a !== 1'b0) begin n_bad++; $display("FAIL r0_pend got=%b exp=0", pend_a); end
  endtask

  task automatic test_pending();
    rsv = 1'b1; rsv_addr = 4'd3; raddr_a = 4'd3;
    #1;
    n_cmp++; if (pend_a !== 1'b0) begin n_bad++; $display("FAIL pend_no_bypass got=%b exp=0", pend_a); end
    tick();
    rsv_addr = 4'd7;
    n_cmp++; if (pend_cnt !== 5'd1) begin n_bad++; $display("FAIL rsv3_cnt got=%0d exp=1", pend_cnt); end
    n_cmp++; if (pend_a !== 1'b1) begin n_bad++; $display("FAIL rsv3_pend_a got=%b exp=1", pend_a); end
    tick();
    n_cmp++; if (pend_cnt !== 5'd2) begin n_bad++; $display("FAIL rsv7_cnt got=%0d exp=2", pend_cnt); end
    tick();
    n_cmp++; if (pend_cnt !== 5'd2) begin n_bad++; $display("FAIL rsv7_again_cnt got=%0d exp=2", pend_cnt); end
    idle();
    we = 1'b1; waddr = 4'd3; wdata = 32'hFFFFFFFF; wbe = 4'b0000;
    tick();
    idle();
    n_cmp++; if (pend_cnt !== 5'd1) begin n_bad++; $display("FAIL wr3_cnt got=%0d exp=1", pend_cnt); end
    n_cmp++; if (pend_a !== 1'b0) begin n_bad++; $display("FAIL wr3_pend_a got=%b exp=0", pend_a); end
    n_cmp++; if (rdata_a !== 32'd0) begin n_bad++; $display("FAIL wr3_zero_be got=%h exp=0", rdata_a); end
    we = 1'b1; waddr = 4'd9; wdata = 32'h00000009; wbe = 4'b1111;
    tick();
    n_cmp++; if (pend_cnt !== 5'd1) begin n_bad++; $display("FAIL wr_nonpend_cnt got=%0d exp=1", pend_cnt); end
    we = 1'b1; waddr = 4'd7; wdata = 32'hCAFEF00D; wbe = 4'b1111;
    rsv = 1'b1; rsv_addr = 4'd7; raddr_b = 4'd7;
    tick();
    idle();
    n_cmp++; if (pend_cnt !== 5'd1) begin n_bad++; $display("FAIL rsv_wr7_cnt got=%0d exp=1", pend_cnt); end
    n_cmp++; if (pend_b !== 1'b1) begin n_bad++; $display("FAIL rsv_wr7_pend_b got=%b exp=1", pend_b); end
    n_cmp++; if (rdata_b !== 32'hCAFEF00D) begin n_bad++; $display("FAIL rsv_wr7_data got=%h exp=cafef00d", rdata_b); end
  endtask

  task automatic test_clear();
    we = 1'b1; waddr = 4'd5; wdata = 32'hDEADBEEF; wbe = 4'b1111;
    tick();
    idle();
    raddr_a = 4'd5; raddr_b = 4'd7;
    #1;
    n_cmp++; if (pend_b !== 1'b1) begin n_bad++; $display("FAIL pre_clear_pend got=%b exp=1", pend_b); end
    clear = 1'b1;
    #1;
    n_cmp++; if (rdata_a !== 32'd0) begin n_bad++; $display("FAIL clear_rdata got=%h exp=0", rdata_a); end
    n_cmp++; if (pend_b !== 1'b0) begin n_bad++; $display("FAIL clear_pend got=%b exp=0", pend_b); end
    n_cmp++; if (pend_cnt !== 5'd0) begin n_bad++; $display("FAIL clear_cnt got=%0d exp=0", pend_cnt); end
    we = 1'b1; waddr = 4'd6; wdata = 32'h12345678; wbe = 4'b1111;
    rsv = 1'b1; rsv_addr = 4'd6;
    tick();
    clear = 1'b0;
    idle();
    raddr_a = 4'd6;
    #1;
    n_cmp++; if (rdata_a !== 32'd0) begin n_bad++; $display("FAIL we_during_clear got=%h exp=0", rdata_a); end
    n_cmp++; if (pend_cnt !== 5'd0) begin n_bad++; $display("FAIL rsv_during_clear got=%0d exp=0", pend_cnt); end
    we = 1'b1; waddr = 4'd6; wdata = 32'h000000AA; wbe = 4'b0001;
    tick();
    idle();
    n_cmp++; if (rdata_a !== 32'h000000AA) begin n_bad++; $display("FAIL post_clear_write got=%h exp=000000aa", rdata_a); end
  endtask

  task automatic test_small();
    s_we = 1'b1; s_waddr = 2'd0; s_wdata = 16'hABCD; s_wbe = 2'b11;
    tick();
    s_waddr = 2'd3;
    tick();
    s_waddr = 2'd1; s_wdata = 16'h1234; s_wbe = 2'b01;
    tick();
    s_we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_rsv = 1'b1; s_rsv_addr = 2'(i);
      tick();
      n_cmp++;
      if (s_pend_cnt !== 3'(i + 1)) begin
        n_bad++; $display("FAIL small_rsv_cnt%0d got=%0d exp=%0d", i, s_pend_cnt, i + 1);
      end
    end
    s_rsv = 1'b0; s_raddr_a = 2'd0; s_raddr_b = 2'd3;
    #1;
    n_cmp++; if (s_rdata_a !== 16'hABCD) begin n_bad++; $display("FAIL small_r0 got=%h exp=abcd", s_rdata_a); end
    n_cmp++; if (s_rdata_b !== 16'hABCD) begin n_bad++; $display("FAIL small_r3 got=%h exp=abcd", s_rdata_b); end
    n_cmp++; if (s_pend_a !== 1'b1) begin n_bad++; $display("FAIL small_r0_pend got=%b exp=1", s_pend_a); end
    s_raddr_a = 2'd1;
    #1;
    n_cmp++; if (s_rdata_a !== 16'h0034) begin n_bad++; $display("FAIL small_r1_be got=%h exp=0034", s_rdata_a); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_zero_reg();
    test_pending();
    test_clear();
    test_small();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
